// File: rtl/sprite_motion_engine_pkg.sv
// -----------------------------------------------------------------------------
// sprite_motion_engine_pkg
// Shared definitions for the sprite motion engine:
//   - one-hot direction encodings (RIGHT/UP/DOWN/LEFT, NONE = stopped)
//   - FSM state encodings (IDLE, REQ, APPLY, DONE)
//   - default step size and wrap bounds of the playfield
//   - is_onehot4(): qualifies a direction request
// -----------------------------------------------------------------------------
package sprite_motion_engine_pkg;

  localparam logic [3:0] DIR_NONE  = 4'b0000;
  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_REQ   = 2'd1;
  localparam state_t ST_APPLY = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam int STEP_DEF  = 16;
  localparam int X_MIN_DEF = 343;
  localparam int X_MAX_DEF = 1607;
  localparam int Y_MIN_DEF = 34;
  localparam int Y_MAX_DEF = 818;

  // A request is accepted only when exactly one direction bit is set.
  function automatic logic is_onehot4(input logic [3:0] d);
    is_onehot4 = (d == DIR_RIGHT) || (d == DIR_UP) ||
                 (d == DIR_DOWN)  || (d == DIR_LEFT);
  endfunction

endpackage

// File: rtl/sprite_motion_engine_if.sv
// -----------------------------------------------------------------------------
// sprite_motion_engine_if
// Valid-move query channel between the motion engine and the maze lookup.
//   vm_req   : query pending (engine -> lookup)
//   vm_x/y   : tile-centre position being queried
//   vm_ack   : query answered (lookup -> engine)
//   vm_moves : legal-direction mask, valid only while vm_ack = 1
// Modports: master = engine side, slave = lookup side.
// -----------------------------------------------------------------------------
interface sprite_motion_engine_if #(
  parameter int X_W = 11,
  parameter int Y_W = 10
);
  logic           vm_req;
  logic [X_W-1:0] vm_x;
  logic [Y_W-1:0] vm_y;
  logic           vm_ack;
  logic [3:0]     vm_moves;

  modport master (output vm_req, vm_x, vm_y, input vm_ack, vm_moves);
  modport slave  (input vm_req, vm_x, vm_y, output vm_ack, vm_moves);
endinterface

// File: rtl/sprite_motion_engine_wrap_step.sv
// -----------------------------------------------------------------------------
// sprite_motion_engine_wrap_step
// Combinational one-tile step with toroidal wrap at the playfield bounds.
//   x, y           : current position
//   dir            : one-hot direction, DIR_NONE leaves the position unchanged
//   next_x, next_y : position after the step
// -----------------------------------------------------------------------------
module sprite_motion_engine_wrap_step
  import sprite_motion_engine_pkg::*;
#(
  parameter int X_W   = 11,
  parameter int Y_W   = 10,
  parameter int STEP  = STEP_DEF,
  parameter int X_MIN = X_MIN_DEF,
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MIN = Y_MIN_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [3:0]     dir,
  output logic [X_W-1:0] next_x,
  output logic [Y_W-1:0] next_y
);

  // One extra bit of headroom so x+STEP cannot overflow. The lower-bound
  // tests compare against MIN+STEP so that x-STEP never has to go negative.
  localparam logic [X_W:0]   STEP_X = (X_W+1)'(STEP);
  localparam logic [Y_W:0]   STEP_Y = (Y_W+1)'(STEP);
  localparam logic [X_W:0]   X_HI   = (X_W+1)'(X_MAX);
  localparam logic [X_W:0]   X_LO   = (X_W+1)'(X_MIN + STEP);
  localparam logic [Y_W:0]   Y_HI   = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W:0]   Y_LO   = (Y_W+1)'(Y_MIN + STEP);
  localparam logic [X_W-1:0] X_MIN_C = X_W'(X_MIN);
  localparam logic [X_W-1:0] X_MAX_C = X_W'(X_MAX);
  localparam logic [Y_W-1:0] Y_MIN_C = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] Y_MAX_C = Y_W'(Y_MAX);

  logic [X_W:0] x_ext_s, x_inc_s, x_dec_s;
  logic [Y_W:0] y_ext_s, y_inc_s, y_dec_s;

  assign x_ext_s = {1'b0, x};
  assign y_ext_s = {1'b0, y};
  assign x_inc_s = x_ext_s + STEP_X;
  assign x_dec_s = x_ext_s - STEP_X;
  assign y_inc_s = y_ext_s + STEP_Y;
  assign y_dec_s = y_ext_s - STEP_Y;

  // Select the stepped coordinate, wrapping to the opposite bound on exit.
  always_comb begin
    next_x = x;
    next_y = y;
    case (dir)
      DIR_RIGHT: if (x_inc_s > X_HI) next_x = X_MIN_C; else next_x = x_inc_s[X_W-1:0];
      DIR_LEFT:  if (x_ext_s < X_LO) next_x = X_MAX_C; else next_x = x_dec_s[X_W-1:0];
      DIR_DOWN:  if (y_inc_s > Y_HI) next_y = Y_MIN_C; else next_y = y_inc_s[Y_W-1:0];
      DIR_UP:    if (y_ext_s < Y_LO) next_y = Y_MAX_C; else next_y = y_dec_s[Y_W-1:0];
      default: begin
        next_x = x;
        next_y = y;
      end
    endcase
  end

endmodule

// File: rtl/sprite_motion_engine.sv
// -----------------------------------------------------------------------------
// sprite_motion_engine
// On each tick, walks all sprite channels in order: queries the legal moves at
// the channel's tile, then turns / continues / stops it and steps one tile.
//   slower_clk, rst : clock, synchronous active-high reset
//   tick            : starts one pass (dropped, and overrun set, while busy)
//   dir_req         : per-channel one-hot direction request (4 bits each)
//   vm              : valid-move query channel (master side)
//   pos_x, pos_y    : per-channel positions
//   cur_dir         : per-channel direction of travel, 0000 = stopped
//   busy, done      : pass in progress / one-cycle end-of-pass pulse
//   overrun         : sticky, a tick arrived while busy
//   collision       : only with SPRITE_COLLISION_EN defined; pulses with done
//                     when channel 0 shares its tile with any other channel
// -----------------------------------------------------------------------------
module sprite_motion_engine
  import sprite_motion_engine_pkg::*;
#(
  parameter int NUM_SPRITES = 5,
  parameter int X_W         = 11,
  parameter int Y_W         = 10,
  parameter int STEP        = STEP_DEF,
  parameter int X_MIN       = X_MIN_DEF,
  parameter int X_MAX       = X_MAX_DEF,
  parameter int Y_MIN       = Y_MIN_DEF,
  parameter int Y_MAX       = Y_MAX_DEF,
  parameter logic [NUM_SPRITES*X_W-1:0] RESET_X =
    {11'd615, 11'd503, 11'd615, 11'd663, 11'd967},
  parameter logic [NUM_SPRITES*Y_W-1:0] RESET_Y =
    {10'd370, 10'd66, 10'd258, 10'd434, 10'd66}
) (
  input  logic                       slower_clk,
  input  logic                       rst,
  input  logic                       tick,
  input  logic [NUM_SPRITES*4-1:0]   dir_req,
  sprite_motion_engine_if.master     vm,
  output logic [NUM_SPRITES*X_W-1:0] pos_x,
  output logic [NUM_SPRITES*Y_W-1:0] pos_y,
  output logic [NUM_SPRITES*4-1:0]   cur_dir,
  output logic                       busy,
  output logic                       done,
  output logic                       overrun
`ifdef SPRITE_COLLISION_EN
  ,
  output logic                       collision
`endif
);

  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

  state_t           state_r, state_n;
  logic [IDX_W-1:0] idx_r, idx_n;
  logic [3:0]       moves_r, moves_n;
  logic [X_W-1:0]   pos_x_r [NUM_SPRITES];
  logic [Y_W-1:0]   pos_y_r [NUM_SPRITES];
  logic [3:0]       dir_r   [NUM_SPRITES];
  logic [3:0]       pend_r  [NUM_SPRITES];
  logic [X_W-1:0]   pos_x_n [NUM_SPRITES];
  logic [Y_W-1:0]   pos_y_n [NUM_SPRITES];
  logic [3:0]       dir_n   [NUM_SPRITES];
  logic [3:0]       pend_n  [NUM_SPRITES];
  logic             vm_req_r, busy_r, done_r, overrun_r;
  logic [X_W-1:0]   vm_x_r;
  logic [Y_W-1:0]   vm_y_r;
  logic [3:0]       step_dir_s;
  logic             take_pend_s;
  logic [X_W-1:0]   step_x_s;
  logic [Y_W-1:0]   step_y_s;

  // Pass sequencer: one REQ/APPLY pair per channel, then a single DONE cycle.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    moves_n = moves_r;
    case (state_r)
      ST_IDLE: begin
        if (tick) begin
          state_n = ST_REQ;
          idx_n   = '0;
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (vm.vm_ack) begin
          state_n = ST_APPLY;
          moves_n = vm.vm_moves;
        end else begin
          state_n = ST_REQ;
        end
      end
      ST_APPLY: begin
        if (idx_r == LAST_IDX) begin
          state_n = ST_DONE;
        end else begin
          state_n = ST_REQ;
          idx_n   = idx_r + IDX_W'(1);
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Turn decision for the active channel: a legal pending turn wins, else keep
  // going if legal, else stop. Stopping yields DIR_NONE, which also means no step.
  always_comb begin
    if ((pend_r[idx_r] & moves_r) != 4'b0000) begin
      step_dir_s  = pend_r[idx_r];
      take_pend_s = 1'b1;
    end else if ((dir_r[idx_r] & moves_r) != 4'b0000) begin
      step_dir_s  = dir_r[idx_r];
      take_pend_s = 1'b0;
    end else begin
      step_dir_s  = DIR_NONE;
      take_pend_s = 1'b0;
    end
  end

  sprite_motion_engine_wrap_step #(
    .X_W(X_W), .Y_W(Y_W), .STEP(STEP),
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX)
  ) u_wrap_step (
    .x      (pos_x_r[idx_r]),
    .y      (pos_y_r[idx_r]),
    .dir    (step_dir_s),
    .next_x (step_x_s),
    .next_y (step_y_s)
  );

  // Per-channel next state: APPLY updates the active channel; a fresh one-hot
  // request lands in pending afterwards so it is never lost to the clear.
  always_comb begin
    for (int i = 0; i < NUM_SPRITES; i++) begin
      pos_x_n[i] = pos_x_r[i];
      pos_y_n[i] = pos_y_r[i];
      dir_n[i]   = dir_r[i];
      pend_n[i]  = pend_r[i];
      if ((state_r == ST_APPLY) && (idx_r == IDX_W'(i))) begin
        pos_x_n[i] = step_x_s;
        pos_y_n[i] = step_y_s;
        dir_n[i]   = step_dir_s;
        if (take_pend_s) pend_n[i] = DIR_NONE; else pend_n[i] = pend_r[i];
      end else begin
        dir_n[i] = dir_r[i];
      end
      if (is_onehot4(dir_req[i*4 +: 4])) pend_n[i] = dir_req[i*4 +: 4];
      else pend_n[i] = pend_n[i];
    end
  end

`ifdef SPRITE_COLLISION_EN
  logic hit_s, collision_r;

  // Channel 0 against every other channel, on the positions the pass ends with.
  always_comb begin
    hit_s = 1'b0;
    for (int i = 1; i < NUM_SPRITES; i++) begin
      if ((pos_x_n[0] == pos_x_n[i]) && (pos_y_n[0] == pos_y_n[i])) hit_s = 1'b1;
      else hit_s = hit_s;
    end
  end
`endif

  // State and output registers; outputs are decoded from the next state so they
  // line up with the state they describe.
  always_ff @(posedge slower_clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      idx_r     <= '0;
      moves_r   <= 4'b0000;
      vm_req_r  <= 1'b0;
      vm_x_r    <= RESET_X[X_W-1:0];
      vm_y_r    <= RESET_Y[Y_W-1:0];
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      overrun_r <= 1'b0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pos_x_r[i] <= RESET_X[i*X_W +: X_W];
        pos_y_r[i] <= RESET_Y[i*Y_W +: Y_W];
        dir_r[i]   <= DIR_NONE;
        pend_r[i]  <= DIR_NONE;
      end
`ifdef SPRITE_COLLISION_EN
      collision_r <= 1'b0;
`endif
    end else begin
      state_r   <= state_n;
      idx_r     <= idx_n;
      moves_r   <= moves_n;
      vm_req_r  <= (state_n == ST_REQ);
      vm_x_r    <= pos_x_n[idx_n];
      vm_y_r    <= pos_y_n[idx_n];
      busy_r    <= (state_n != ST_IDLE);
      done_r    <= (state_n == ST_DONE);
      overrun_r <= overrun_r | (tick && (state_r != ST_IDLE));
      for (int i = 0; i < NUM_SPRITES; i++) begin
        pos_x_r[i] <= pos_x_n[i];
        pos_y_r[i] <= pos_y_n[i];
        dir_r[i]   <= dir_n[i];
        pend_r[i]  <= pend_n[i];
      end
`ifdef SPRITE_COLLISION_EN
      collision_r <= (state_n == ST_DONE) && hit_s;
`endif
    end
  end

  for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_pack
    assign pos_x[g*X_W +: X_W] = pos_x_r[g];
    assign pos_y[g*Y_W +: Y_W] = pos_y_r[g];
    assign cur_dir[g*4 +: 4]   = dir_r[g];
  end

  assign vm.vm_req = vm_req_r;
  assign vm.vm_x   = vm_x_r;
  assign vm.vm_y   = vm_y_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign overrun   = overrun_r;
`ifdef SPRITE_COLLISION_EN
  assign collision = collision_r;
`endif

endmodule

// File: tb/tb_sprite_motion_engine.sv
// -----------------------------------------------------------------------------
// tb_sprite_motion_engine
// Self-checking bench for sprite_motion_engine (default parameters). Build with
// SPRITE_COLLISION_EN defined to include the collision sequence.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sprite_motion_engine;
  import sprite_motion_engine_pkg::*;

  localparam int NS = 5;
  localparam int XW = 11;
  localparam int YW = 10;

  typedef struct {
    logic [NS*XW-1:0] px;
    logic [NS*YW-1:0] py;
    logic [NS*4-1:0]  cd;
    logic             col;
    int               cycles;
  } exp_t;

  typedef struct {
    logic [3:0] dir;
    logic [3:0] mask;
    int         x;
    int         y;
    logic [3:0] cd;
  } vec_t;

  logic             slower_clk;
  logic             rst;
  logic             tick;
  logic [NS*4-1:0]  dir_req;
  logic [NS*XW-1:0] pos_x;
  logic [NS*YW-1:0] pos_y;
  logic [NS*4-1:0]  cur_dir;
  logic             busy, done, overrun;
`ifdef SPRITE_COLLISION_EN
  logic             collision;
`endif

  sprite_motion_engine_if #(.X_W(XW), .Y_W(YW)) vm ();

  sprite_motion_engine #(.NUM_SPRITES(NS), .X_W(XW), .Y_W(YW)) dut (
    .slower_clk (slower_clk),
    .rst        (rst),
    .tick       (tick),
    .dir_req    (dir_req),
    .vm         (vm),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .cur_dir    (cur_dir),
    .busy       (busy),
    .done       (done),
    .overrun    (overrun)
`ifdef SPRITE_COLLISION_EN
    ,
    .collision  (collision)
`endif
  );

  int         n_checks = 0;
  int         n_fail   = 0;
  exp_t       sb_q[$];
  int         rst_x [NS];
  int         rst_y [NS];
  int         mx [NS];
  int         my [NS];
  logic [3:0] md [NS];
  vec_t       vecs [13];
  logic [3:0] ack_mask  = 4'b1111;
  int         ack_delay = 0;
  int         req_wait  = 0;

  initial slower_clk = 1'b0;
  always #5 slower_clk = ~slower_clk;

  // Maze-lookup responder: answers a query after ack_delay waiting cycles.
  always @(negedge slower_clk) begin
    if (vm.vm_req) begin
      if (req_wait >= ack_delay) begin
        vm.vm_ack   = 1'b1;
        vm.vm_moves = ack_mask;
      end else begin
        vm.vm_ack   = 1'b0;
        vm.vm_moves = 4'b0000;
      end
      req_wait = req_wait + 1;
    end else begin
      vm.vm_ack   = 1'b0;
      vm.vm_moves = 4'b0000;
      req_wait    = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NS; c++) begin
      mx[c] = rst_x[c];
      my[c] = rst_y[c];
      md[c] = DIR_NONE;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge slower_clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic push_exp(input logic col, input int cycles);
    exp_t e;
    for (int c = 0; c < NS; c++) begin
      e.px[c*XW +: XW] = XW'(mx[c]);
      e.py[c*YW +: YW] = YW'(my[c]);
      e.cd[c*4 +: 4]   = md[c];
    end
    e.col    = col;
    e.cycles = cycles;
    sb_q.push_back(e);
  endtask

  // Waits (bounded) for done, then pops the scoreboard and compares.
  task automatic wait_done(input int cyc0);
    int   cyc;
    exp_t e;
    cyc = cyc0;
    while (!done && cyc < 400) begin
      @(negedge slower_clk);
      cyc++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL pass_timeout: no done after %0d cycles, expected done", cyc);
      sb_q.delete();
    end else begin
      e = sb_q.pop_front();
      check("pos_x", 64'(pos_x), 64'(e.px));
      check("pos_y", 64'(pos_y), 64'(e.py));
      check("cur_dir", 64'(cur_dir), 64'(e.cd));
      if (e.cycles > 0) check("done_latency", 64'(cyc), 64'(e.cycles));
`ifdef SPRITE_COLLISION_EN
      check("collision_at_done", 64'(collision), 64'(e.col));
`endif
      @(negedge slower_clk);
      check("done_one_cycle", 64'(done), 64'(0));
      check("busy_after_pass", 64'(busy), 64'(0));
`ifdef SPRITE_COLLISION_EN
      check("collision_one_cycle", 64'(collision), 64'(0));
`endif
    end
  endtask

  task automatic run_pass(input logic col, input int cycles);
    push_exp(col, cycles);
    tick = 1'b1;
    @(negedge slower_clk);
    tick = 1'b0;
    wait_done(1);
  endtask

  task automatic request(input int ch, input logic [3:0] d, input logic [3:0] mask);
    ack_mask = mask;
    dir_req[ch*4 +: 4] = d;
    @(negedge slower_clk);
    dir_req = '0;
  endtask

  function automatic int wrap_right(input int x);
    return (x + 16 > 1607) ? 343 : x + 16;
  endfunction
  function automatic int wrap_left(input int x);
    return (x - 16 < 343) ? 1607 : x - 16;
  endfunction
  function automatic int wrap_up(input int y);
    return (y - 16 < 34) ? 818 : y - 16;
  endfunction

  initial begin
    rst_x = '{967, 663, 615, 503, 615};
    rst_y = '{66, 434, 258, 66, 370};
    //        dir      mask     x     y    cur_dir   (channel 0)
    vecs[0]  = '{4'b0001, 4'b1111,  983,  66, 4'b0001};
    vecs[1]  = '{4'b0000, 4'b1111,  999,  66, 4'b0001};
    vecs[2]  = '{4'b0100, 4'b0001, 1015,  66, 4'b0001};
    vecs[3]  = '{4'b0000, 4'b0100, 1015,  82, 4'b0100};
    vecs[4]  = '{4'b0000, 4'b0000, 1015,  82, 4'b0000};
    vecs[5]  = '{4'b1000, 4'b0010, 1015,  82, 4'b0000};
    vecs[6]  = '{4'b0000, 4'b1000,  999,  82, 4'b1000};
    vecs[7]  = '{4'b0011, 4'b1111,  983,  82, 4'b1000};
    vecs[8]  = '{4'b0010, 4'b0010,  983,  66, 4'b0010};
    vecs[9]  = '{4'b0000, 4'b0010,  983,  50, 4'b0010};
    vecs[10] = '{4'b0000, 4'b0010,  983,  34, 4'b0010};
    vecs[11] = '{4'b0000, 4'b0010,  983, 818, 4'b0010};
    vecs[12] = '{4'b0100, 4'b0100,  983,  34, 4'b0100};

    rst = 1'b1;
    tick = 1'b0;
    dir_req = '0;
    repeat (3) @(negedge slower_clk);
    rst = 1'b0;
    model_reset();
    @(negedge slower_clk);

    // Reset state
    check("rst_ch0_x", 64'(pos_x[10:0]), 64'(967));
    check("rst_ch0_y", 64'(pos_y[9:0]), 64'(66));
    check("rst_ch4_x", 64'(pos_x[54:44]), 64'(615));
    check("rst_ch4_y", 64'(pos_y[49:40]), 64'(370));
    check("rst_cur_dir", 64'(cur_dir), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_overrun", 64'(overrun), 64'(0));
    check("rst_vm_req", 64'(vm.vm_req), 64'(0));

    // Table-driven passes on channel 0 (turns, stops, invalid request, y wrap)
    for (int i = 0; i < 13; i++) begin
      request(0, vecs[i].dir, vecs[i].mask);
      mx[0] = vecs[i].x;
      my[0] = vecs[i].y;
      md[0] = vecs[i].cd;
      run_pass(1'b0, (i == 0) ? 11 : 0);
    end

    // Channel 0 heads right through x=1607 and wraps to 343
    request(0, DIR_RIGHT, 4'b0001);
    for (int k = 0; k < 41; k++) begin
      mx[0] = wrap_right(mx[0]);
      md[0] = DIR_RIGHT;
      run_pass(1'b0, 0);
    end
    check("ch0_x_wrapped", 64'(pos_x[10:0]), 64'(359));

    // Channel 1 heads up through y=34 and wraps to 818
    do_reset();
    request(1, DIR_UP, 4'b0010);
    for (int k = 0; k < 27; k++) begin
      my[1] = wrap_up(my[1]);
      md[1] = DIR_UP;
      run_pass(1'b0, 0);
    end
    check("ch1_y_wrapped", 64'(pos_y[19:10]), 64'(802));

    // Channel 2: illegal turn stays pending until the mask allows it
    do_reset();
    request(2, DIR_RIGHT, 4'b1111);
    mx[2] = 631; md[2] = DIR_RIGHT;
    run_pass(1'b0, 0);
    request(2, DIR_UP, 4'b0001);
    mx[2] = 647;
    run_pass(1'b0, 0);
    request(2, DIR_NONE, 4'b0011);
    my[2] = 242; md[2] = DIR_UP;
    run_pass(1'b0, 0);

    // Delayed acknowledge with a second tick mid-pass
    do_reset();
    ack_delay = 3;
    ack_mask  = 4'b1111;
    push_exp(1'b0, 0);
    tick = 1'b1;
    @(negedge slower_clk);
    tick = 1'b0;
    check("vm_req_raised", 64'(vm.vm_req), 64'(1));
    check("vm_x_ch0", 64'(vm.vm_x), 64'(967));
    check("vm_y_ch0", 64'(vm.vm_y), 64'(66));
    for (int k = 0; k < 2; k++) begin
      @(negedge slower_clk);
      check("vm_req_held", 64'(vm.vm_req), 64'(1));
      check("vm_x_held", 64'(vm.vm_x), 64'(967));
    end
    tick = 1'b1;
    @(negedge slower_clk);
    tick = 1'b0;
    check("overrun_set", 64'(overrun), 64'(1));
    wait_done(4);
    repeat (3) @(negedge slower_clk);
    check("dropped_tick_idle", 64'(busy), 64'(0));
    check("overrun_sticky", 64'(overrun), 64'(1));
    do_reset();
    check("overrun_cleared", 64'(overrun), 64'(0));
    ack_delay = 0;

    // Reset in the middle of a pass discards the partial update
    request(0, DIR_RIGHT, 4'b1111);
    tick = 1'b1;
    @(negedge slower_clk);
    tick = 1'b0;
    repeat (2) @(negedge slower_clk);
    check("mid_pass_ch0_x", 64'(pos_x[10:0]), 64'(983));
    rst = 1'b1;
    @(negedge slower_clk);
    rst = 1'b0;
    check("abort_ch0_x", 64'(pos_x[10:0]), 64'(967));
    check("abort_cur_dir", 64'(cur_dir), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_vm_req", 64'(vm.vm_req), 64'(0));
    model_reset();

    // Pending request cleared by reset; reset wins over a coincident tick
    request(0, DIR_RIGHT, 4'b1111);
    rst = 1'b1;
    tick = 1'b1;
    @(negedge slower_clk);
    rst = 1'b0;
    tick = 1'b0;
    check("rst_over_tick", 64'(busy), 64'(0));
    run_pass(1'b0, 11);

`ifdef SPRITE_COLLISION_EN
    // Channel 0 walks left onto channel 3's tile at (503,66)
    do_reset();
    request(0, DIR_LEFT, 4'b1000);
    for (int k = 0; k < 29; k++) begin
      mx[0] = wrap_left(mx[0]);
      md[0] = DIR_LEFT;
      run_pass((k == 28) ? 1'b1 : 1'b0, 0);
    end
    rst = 1'b1;
    @(negedge slower_clk);
    rst = 1'b0;
    check("rst_ch0_x_after_col", 64'(pos_x[10:0]), 64'(967));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
